// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I controller.
//   - FSM state codes (4-bit)
//   - supported opcode constants
//   - alu_control codes and the alu_op modes understood by alu_decoder
//   - alu_src_a, alu_src_b, result_src and imm_src encodings
package riscv_ctrl_pkg;

  // FSM states
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  // Supported opcodes
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // alu_decoder modes
  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;

  // ALU A operand select
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_MEM_DATA = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  // Immediate formats
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder.
//   alu_op      in  2  00 = add, 01 = sub, 10 = decode from funct3/funct7
//   funct3      in  3  instruction bits [14:12]
//   op5         in  1  opcode bit 5 (1 for R-type, 0 for immediate forms)
//   funct7_5    in  1  instruction bit 30
//   alu_control out 3  ALU operation code
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_R: begin
        case (funct3)
          // Bit 30 selects sub only for register-register forms; an
          // immediate add reuses that bit as part of the immediate.
          3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I controller: sequences fetch, decode, execute, memory and
// writeback over one shared ALU and a unified instruction/data memory.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   opcode, funct3, funct7_5 fields from the instruction register
//   zero                     ALU zero flag (branch condition)
//   mem_ready                memory finished the current request this cycle
//   mem_req, mem_write       memory request and write strobe
//   adr_src                  memory address: 0 = PC, 1 = ALUOut
//   ir_write, pc_write       IR/old-PC load, PC load
//   reg_write                register file write enable
//   alu_src_a, alu_src_b     ALU operand selects
//   result_src               result bus select
//   imm_src                  immediate format
//   alu_control              ALU operation
//   illegal                  high while parked on an unsupported opcode
//   cycle_cnt, instret_cnt   cycle and retired-instruction counters
//
// Memory handshake: a transfer completes in a cycle where mem_req and
// mem_ready are both 1. mem_req and the address/write selects stay stable
// until that cycle; mem_ready is ignored whenever mem_req is 0.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  imm_src,
  output logic [2:0]  alu_control,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  logic [3:0] state;
  logic [3:0] next_state;
  logic [1:0] alu_op;

  // Unqualified strobes; reset masks them below.
  logic mem_req_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic pc_write_raw;
  logic reg_write_raw;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECUTER;
          OP_ADDI:      next_state = S_EXECUTEI;
          OP_JAL:       next_state = S_JAL;
          OP_BEQ:       next_state = S_BEQ;
          default:      next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: next_state = S_ALUWB;
      S_EXECUTEI: next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_BEQ:      next_state = S_FETCH;
      S_ILLEGAL:  next_state = S_ILLEGAL;
      default:    next_state = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_raw   = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    pc_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    result_src    = RES_ALU_OUT;
    alu_op        = ALU_OP_ADD;
    case (state)
      S_FETCH: begin
        mem_req_raw  = 1'b1;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_FOUR;
        result_src   = RES_ALU;
        // IR and PC may only load in the cycle the fetch completes.
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: begin
        // Speculatively compute old PC + imm as the branch/jump target.
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: begin
        mem_req_raw = 1'b1;
        adr_src     = 1'b1;
      end
      S_MEMWB: begin
        result_src    = RES_MEM_DATA;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_raw   = 1'b1;
        mem_write_raw = 1'b1;
        adr_src       = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_OP_R;
      end
      S_EXECUTEI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_R;
      end
      S_ALUWB: begin
        result_src    = RES_ALU_OUT;
        reg_write_raw = 1'b1;
      end
      S_JAL: begin
        // ALU forms the link value old PC + 4 while ALUOut (target from
        // DECODE) is steered onto the result bus into the PC.
        alu_src_a    = SRC_A_OLD_PC;
        alu_src_b    = SRC_B_FOUR;
        result_src   = RES_ALU_OUT;
        pc_write_raw = 1'b1;
      end
      S_BEQ: begin
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_OP_SUB;
        result_src   = RES_ALU_OUT;
        pc_write_raw = zero;
      end
      default: begin
      end
    endcase
  end

  assign mem_req   = mem_req_raw   & ~rst;
  assign mem_write = mem_write_raw & ~rst;
  assign ir_write  = ir_write_raw  & ~rst;
  assign pc_write  = pc_write_raw  & ~rst;
  assign reg_write = reg_write_raw & ~rst;

  assign illegal = (state == S_ILLEGAL);

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (opcode[5]),
    .funct7_5    (funct7_5),
    .alu_control (alu_control)
  );

  // An instruction retires when the FSM re-enters FETCH from another state;
  // a fetch stall (FETCH -> FETCH) is not a retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (next_state == S_FETCH && state != S_FETCH)
        instret_cnt <= instret_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller. Each cycle the full strobe
// and select vector is compared against a hand-written per-state signature,
// together with the cycle and retired-instruction counters.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_write;
  logic        adr_src;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic [1:0]  imm_src;
  logic [2:0]  alu_control;
  logic        illegal;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  multicycle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .illegal     (illegal),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Signature layout:
  // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
  //  alu_src_a[1:0], alu_src_b[1:0], result_src[1:0], alu_control[2:0], illegal}
  logic [15:0] sig;
  assign sig = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_control, illegal};

  localparam logic [15:0] SIG_RST_FETCH = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,3'b000,1'b0};
  localparam logic [15:0] SIG_FETCH_RDY = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b10,2'b10,3'b000,1'b0};
  localparam logic [15:0] SIG_FETCH_WT  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,3'b000,1'b0};
  localparam logic [15:0] SIG_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,3'b000,1'b0};
  localparam logic [15:0] SIG_MEMADR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,3'b000,1'b0};
  localparam logic [15:0] SIG_MEMREAD   = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,1'b0};
  localparam logic [15:0] SIG_MEMWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b01,3'b000,1'b0};
  localparam logic [15:0] SIG_MEMWRITE  = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,1'b0};
  localparam logic [15:0] SIG_ABORT_WR  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,1'b0};
  localparam logic [15:0] SIG_EXR_SUB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,3'b001,1'b0};
  localparam logic [15:0] SIG_EXR_AND   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,3'b010,1'b0};
  localparam logic [15:0] SIG_EXI_ADD   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,3'b000,1'b0};
  localparam logic [15:0] SIG_EXI_SLT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,3'b101,1'b0};
  localparam logic [15:0] SIG_ALUWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'b000,1'b0};
  localparam logic [15:0] SIG_JAL       = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,2'b10,2'b00,3'b000,1'b0};
  localparam logic [15:0] SIG_BEQ_T     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b00,3'b001,1'b0};
  localparam logic [15:0] SIG_BEQ_NT    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,3'b001,1'b0};
  localparam logic [15:0] SIG_ILLEGAL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,1'b1};

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cyc = 32'd0;
  logic [31:0] exp_ret = 32'd0;

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs already applied after the falling edge; check the
  // combinational outputs and counters, then advance past the rising edge.
  task automatic cyc(input string tag, input logic [15:0] exp_sig, input logic retire);
    #1;
    check(tag, {16'h0, sig}, {16'h0, exp_sig});
    check({tag, ".cycle"}, cycle_cnt, exp_cyc);
    check({tag, ".instret"}, instret_cnt, exp_ret);
    @(posedge clk);
    if (rst) begin
      exp_cyc = 32'd0;
      exp_ret = 32'd0;
    end else begin
      exp_cyc = exp_cyc + 32'd1;
      if (retire) exp_ret = exp_ret + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode   = op;
    funct3   = f3;
    funct7_5 = f7;
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);

    // Reset held: FETCH selects visible, strobes masked even with mem_ready=1
    cyc("rst", SIG_RST_FETCH, 1'b0);
    rst = 1'b0;

    // lw, zero-wait: 5 cycles
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc("lw.fetch", SIG_FETCH_RDY, 1'b0);
    check("lw.imm", {30'd0, imm_src}, 32'd0);
    cyc("lw.decode", SIG_DECODE, 1'b0);
    cyc("lw.memadr", SIG_MEMADR, 1'b0);
    cyc("lw.memread", SIG_MEMREAD, 1'b0);
    cyc("lw.memwb", SIG_MEMWB, 1'b1);

    // sw with two wait cycles in MEMWRITE: 6 cycles
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("sw.fetch", SIG_FETCH_RDY, 1'b0);
    check("sw.imm", {30'd0, imm_src}, 32'd1);
    cyc("sw.decode", SIG_DECODE, 1'b0);
    cyc("sw.memadr", SIG_MEMADR, 1'b0);
    mem_ready = 1'b0;
    cyc("sw.wait1", SIG_MEMWRITE, 1'b0);
    cyc("sw.wait2", SIG_MEMWRITE, 1'b0);
    mem_ready = 1'b1;
    cyc("sw.done", SIG_MEMWRITE, 1'b1);

    // R-type sub
    set_instr(7'b0110011, 3'b000, 1'b1);
    cyc("sub.fetch", SIG_FETCH_RDY, 1'b0);
    cyc("sub.decode", SIG_DECODE, 1'b0);
    cyc("sub.exec", SIG_EXR_SUB, 1'b0);
    cyc("sub.wb", SIG_ALUWB, 1'b1);

    // addi with bit 30 set still adds
    set_instr(7'b0010011, 3'b000, 1'b1);
    cyc("addi.fetch", SIG_FETCH_RDY, 1'b0);
    cyc("addi.decode", SIG_DECODE, 1'b0);
    cyc("addi.exec", SIG_EXI_ADD, 1'b0);
    cyc("addi.wb", SIG_ALUWB, 1'b1);

    // R-type and
    set_instr(7'b0110011, 3'b111, 1'b0);
    cyc("and.fetch", SIG_FETCH_RDY, 1'b0);
    cyc("and.decode", SIG_DECODE, 1'b0);
    cyc("and.exec", SIG_EXR_AND, 1'b0);
    cyc("and.wb", SIG_ALUWB, 1'b1);

    // slti through the immediate path
    set_instr(7'b0010011, 3'b010, 1'b0);
    cyc("slti.fetch", SIG_FETCH_RDY, 1'b0);
    cyc("slti.decode", SIG_DECODE, 1'b0);
    cyc("slti.exec", SIG_EXI_SLT, 1'b0);
    cyc("slti.wb", SIG_ALUWB, 1'b1);

    // beq taken; mem_ready low outside memory states must be ignored
    set_instr(7'b1100011, 3'b000, 1'b0);
    zero = 1'b1;
    cyc("beqt.fetch", SIG_FETCH_RDY, 1'b0);
    check("beq.imm", {30'd0, imm_src}, 32'd2);
    mem_ready = 1'b0;
    cyc("beqt.decode", SIG_DECODE, 1'b0);
    cyc("beqt.beq", SIG_BEQ_T, 1'b1);
    mem_ready = 1'b1;

    // beq not taken
    zero = 1'b0;
    cyc("beqn.fetch", SIG_FETCH_RDY, 1'b0);
    cyc("beqn.decode", SIG_DECODE, 1'b0);
    cyc("beqn.beq", SIG_BEQ_NT, 1'b1);

    // jal with one fetch wait cycle
    set_instr(7'b1101111, 3'b000, 1'b0);
    mem_ready = 1'b0;
    cyc("jal.fwait", SIG_FETCH_WT, 1'b0);
    check("jal.imm", {30'd0, imm_src}, 32'd3);
    mem_ready = 1'b1;
    cyc("jal.fetch", SIG_FETCH_RDY, 1'b0);
    cyc("jal.decode", SIG_DECODE, 1'b0);
    cyc("jal.jal", SIG_JAL, 1'b0);
    cyc("jal.wb", SIG_ALUWB, 1'b1);

    // lw with one wait cycle in MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc("lws.fetch", SIG_FETCH_RDY, 1'b0);
    cyc("lws.decode", SIG_DECODE, 1'b0);
    cyc("lws.memadr", SIG_MEMADR, 1'b0);
    mem_ready = 1'b0;
    cyc("lws.wait", SIG_MEMREAD, 1'b0);
    mem_ready = 1'b1;
    cyc("lws.memread", SIG_MEMREAD, 1'b0);
    cyc("lws.memwb", SIG_MEMWB, 1'b1);

    // sw aborted by reset mid-stall: no write strobe, counters cleared
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("abt.fetch", SIG_FETCH_RDY, 1'b0);
    cyc("abt.decode", SIG_DECODE, 1'b0);
    cyc("abt.memadr", SIG_MEMADR, 1'b0);
    mem_ready = 1'b0;
    cyc("abt.wait", SIG_MEMWRITE, 1'b0);
    rst = 1'b1;
    cyc("abt.rst", SIG_ABORT_WR, 1'b0);
    rst = 1'b0;
    mem_ready = 1'b1;

    // Unsupported opcode parks in ILLEGAL while cycle_cnt keeps counting
    set_instr(7'b0000000, 3'b000, 1'b0);
    cyc("ill.fetch", SIG_FETCH_RDY, 1'b0);
    cyc("ill.decode", SIG_DECODE, 1'b0);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      zero      = i[1];
      cyc("ill.hold", SIG_ILLEGAL, 1'b0);
    end
    mem_ready = 1'b1;
    zero = 1'b0;
    rst = 1'b1;
    cyc("ill.rst", SIG_ILLEGAL, 1'b0);
    rst = 1'b0;
    cyc("ill.recover", SIG_FETCH_RDY, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
